// File: rtl/serial_shift_transmitter.sv
// Parallel-to-serial frame transmitter: start bit, DATA_WIDTH data bits,
// optional even parity, stop bit, each held CLKS_PER_BIT cycles.
module serial_shift_transmitter #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned MSB_FIRST    = 1,
    parameter int unsigned PARITY_EN    = 0
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_serial,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    state_e                state_q,  state_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic [IDX_W-1:0]      idx_q,    idx_d;
    logic [DATA_WIDTH-1:0] shift_q,  shift_d;
    logic                  parity_q, parity_d;
    logic                  serial_q, serial_d;
    logic                  ready_q,  ready_d;
    logic                  busy_q,   busy_d;
    logic                  done_q,   done_d;

    logic                  bit_end_c;
    logic                  next_bit_c;
    logic [DATA_WIDTH-1:0] shifted_c;

    // Next data bit to emit and the shift register with that bit consumed
    always_comb begin
        if (MSB_FIRST != 0) begin
            next_bit_c = shift_q[DATA_WIDTH-1];
            shifted_c  = {shift_q[DATA_WIDTH-2:0], 1'b0};
        end else begin
            next_bit_c = shift_q[0];
            shifted_c  = {1'b0, shift_q[DATA_WIDTH-1:1]};
        end
    end

    assign bit_end_c = (cnt_q == CNT_LAST);

    // State register and registered outputs
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            serial_q <= 1'b1;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            serial_q <= serial_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic; the next line value is registered one edge ahead
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        serial_d = serial_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = bit_end_c ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                serial_d = 1'b1;
                busy_d   = 1'b0;
                ready_d  = 1'b1;
                cnt_d    = '0;
                idx_d    = '0;
                if (i_valid && ready_q) begin
                    state_d  = S_START;
                    shift_d  = i_data;
                    parity_d = ^i_data;
                    serial_d = 1'b0;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            S_START: begin
                if (bit_end_c) begin
                    state_d  = S_DATA;
                    serial_d = next_bit_c;
                    shift_d  = shifted_c;
                    idx_d    = '0;
                end
            end
            S_DATA: begin
                if (bit_end_c) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d  = S_PARITY;
                            serial_d = parity_q;
                        end else begin
                            state_d  = S_STOP;
                            serial_d = 1'b1;
                        end
                    end else begin
                        idx_d    = idx_q + IDX_W'(1);
                        serial_d = next_bit_c;
                        shift_d  = shifted_c;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end_c) begin
                    state_d  = S_STOP;
                    serial_d = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end_c) begin
                    state_d  = S_IDLE;
                    serial_d = 1'b1;
                    ready_d  = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                serial_d = 1'b1;
                ready_d  = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    assign o_ready  = ready_q;
    assign o_serial = serial_q;
    assign o_busy   = busy_q;
    assign o_done   = done_q;

endmodule

// File: tb/tb_serial_shift_transmitter.sv
// Scoreboard bench for serial_shift_transmitter across four parameter sets,
// including a mid-frame asynchronous reset.
module tb_serial_shift_transmitter;

    localparam int NDUT = 4;
    localparam int CFG_W   [NDUT] = '{8, 8, 8, 5};
    localparam int CFG_CPB [NDUT] = '{1, 1, 4, 3};
    localparam int CFG_MSB [NDUT] = '{1, 0, 1, 0};
    localparam int CFG_PAR [NDUT] = '{0, 1, 0, 1};

    typedef struct {
        logic [15:0] bits;
        int          n;
    } frame_t;

    logic clk;
    logic rst_n;
    int   phase;
    int   stim_cnt;
    int   fin_cnt;
    int   n_vec;
    int   n_miss;

    task automatic chk(input string nm, input int g, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s dut%0d t=%0t got=%b expected=%b", nm, g, $time, act, exp);
        end
    endtask

    task automatic chk_n(input string nm, input int g, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s dut%0d t=%0t got=%0d expected=%0d", nm, g, $time, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < NDUT; g++) begin : gen_dut
        localparam int W   = CFG_W[g];
        localparam int CPB = CFG_CPB[g];
        localparam int MSB = CFG_MSB[g];
        localparam int PAR = CFG_PAR[g];
        localparam int L   = (W + 2 + PAR) * CPB;

        logic [W-1:0] data;
        logic         valid;
        logic         ready;
        logic         ser;
        logic         busy;
        logic         done;

        frame_t sb[$];
        bit     m_ready;
        int     m_left;
        int     acc;
        bit     inf;

        serial_shift_transmitter #(
            .DATA_WIDTH  (W),
            .CLKS_PER_BIT(CPB),
            .MSB_FIRST   (MSB),
            .PARITY_EN   (PAR)
        ) u_dut (
            .i_clock  (clk),
            .i_reset_n(rst_n),
            .i_data   (data),
            .i_valid  (valid),
            .o_ready  (ready),
            .o_serial (ser),
            .o_busy   (busy),
            .o_done   (done)
        );

        // Expected line bits of one frame, one entry per serial bit
        function automatic frame_t mk(input logic [W-1:0] d);
            frame_t f;
            logic   par;
            f.bits = '0;
            par    = 1'b0;
            for (int i = 0; i < W; i++) begin
                f.bits[1+i] = (MSB != 0) ? d[W-1-i] : d[i];
                par ^= d[i];
            end
            f.n = W + 2;
            if (PAR != 0) begin
                f.bits[W+1] = par;
                f.n = W + 3;
            end
            f.bits[f.n-1] = 1'b1;
            return f;
        endfunction

        // Reference: accept when ready and valid, busy for L cycles, then ready again
        initial begin
            m_ready = 1'b0;
            m_left  = 0;
            acc     = 0;
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    m_ready = 1'b0;
                    m_left  = 0;
                end else if (m_left != 0) begin
                    m_left--;
                    if (m_left == 0) m_ready = 1'b1;
                end else if (m_ready && valid) begin
                    sb.push_back(mk(data));
                    acc++;
                    m_ready = 1'b0;
                    m_left  = L;
                end else begin
                    m_ready = 1'b1;
                end
            end
        end

        // Monitor: pops a frame when busy rises and checks it cycle by cycle
        initial begin
            frame_t cur;
            int     k;
            bit     dn;
            int     wt;
            inf = 1'b0;
            k   = 0;
            dn  = 1'b0;
            wt  = 0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    inf = 1'b0;
                    dn  = 1'b0;
                    wt  = 0;
                    sb.delete();
                    chk("rst_serial", g, ser, 1'b1);
                    chk("rst_busy", g, busy, 1'b0);
                    chk("rst_ready", g, ready, 1'b0);
                    chk("rst_done", g, done, 1'b0);
                end else begin
                    chk("ready", g, ready, m_ready);
                    if (!inf) begin
                        chk("done", g, done, dn);
                        dn = 1'b0;
                        if (busy) begin
                            if (sb.size() == 0) begin
                                chk("unexpected_busy", g, busy, 1'b0);
                            end else begin
                                cur = sb.pop_front();
                                inf = 1'b1;
                                k   = 0;
                                wt  = 0;
                            end
                        end else begin
                            chk("idle_serial", g, ser, 1'b1);
                            if (sb.size() != 0) begin
                                wt++;
                                if (wt > 8) begin
                                    chk("frame_start_timeout", g, busy, 1'b1);
                                    sb.delete();
                                    wt = 0;
                                end
                            end
                        end
                    end
                    if (inf) begin
                        chk("serial", g, ser, cur.bits[k/CPB]);
                        chk("busy", g, busy, 1'b1);
                        chk("done_in_frame", g, done, 1'b0);
                        k++;
                        if (k == cur.n * CPB) begin
                            inf = 1'b0;
                            dn  = 1'b1;
                        end
                    end
                end
            end
        end

        // Reset must force the outputs without waiting for a clock edge
        initial begin
            forever begin
                @(negedge rst_n);
                #1;
                chk("async_serial", g, ser, 1'b1);
                chk("async_busy", g, busy, 1'b0);
                chk("async_ready", g, ready, 1'b0);
                chk("async_done", g, done, 1'b0);
            end
        end

        task automatic random_run(input int cycles, input int hold_valid);
            for (int c = 0; c < cycles; c++) begin
                @(negedge clk);
                valid = (c < hold_valid) ? 1'b1 : ($urandom_range(0, 3) != 0);
                data  = W'($urandom);
            end
            @(negedge clk);
            valid = 1'b0;
        endtask

        // Stimulus: directed words, then random traffic, around the reset test
        initial begin
            logic [W-1:0] dir [6];
            int           a0;
            int           guard;
            dir[0] = W'(32'hA5);
            dir[1] = W'(32'h01);
            dir[2] = W'(32'h07);
            dir[3] = W'(32'hFF);
            dir[4] = W'(32'h00);
            dir[5] = W'(32'h80);
            valid = 1'b0;
            data  = '0;
            wait (phase == 1);
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                a0    = acc;
                valid = 1'b1;
                data  = dir[i];
                guard = 0;
                while (acc == a0 && guard < 100) begin
                    @(negedge clk);
                    guard++;
                end
                if (acc == a0) chk_n("directed_accept_timeout", g, acc, a0 + 1);
            end
            random_run(400, 80);
            stim_cnt++;
            wait (phase == 2);
            @(negedge clk);
            valid = 1'b1;
            data  = W'($urandom);
            @(negedge clk);
            valid = 1'b0;
            wait (phase == 3);
            random_run(250, 30);
            stim_cnt++;
            wait (phase == 4);
            chk_n("scoreboard_drained", g, sb.size(), 0);
            chk("frame_closed", g, inf, 1'b0);
            fin_cnt++;
        end
    end

    initial begin
        #200000;
        n_miss++;
        $display("FAIL watchdog t=%0t got=timeout expected=completion", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        rst_n    = 1'b0;
        phase    = 0;
        stim_cnt = 0;
        fin_cnt  = 0;
        n_vec    = 0;
        n_miss   = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 phase = 1;
        wait (stim_cnt == NDUT);
        repeat (60) @(posedge clk);
        #1 phase = 2;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 phase = 3;
        wait (stim_cnt == 2 * NDUT);
        repeat (60) @(posedge clk);
        #1 phase = 4;
        wait (fin_cnt == NDUT);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
